// File: rtl/rs_slot_alloc_pkg.sv
// Shared sizing and typedefs for the reservation-station slot allocator.
package rs_slot_alloc_pkg;

    localparam int RS_SIZE = 8;

    typedef logic [$clog2(RS_SIZE)-1:0] rs_idx_t;
    typedef logic [RS_SIZE-1:0]         rs_oh_t;

endpackage

// File: rtl/rs_slot_alloc_dec.sv
// Binary-to-one-hot decoder for RS entries; in_range flags indices below N.
module binary_to_onehot_RS
    import rs_slot_alloc_pkg::*;
#(
    parameter int N = RS_SIZE
) (
    input  logic [$clog2(N)-1:0] bin,
    output logic [N-1:0]         oh,
    output logic                 in_range
);

    localparam int IW = $clog2(N);

    always_comb begin
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = (bin == IW'(i));
        end
    end

    // Widened so the compare stays meaningful when N is a power of two.
    assign in_range = ({1'b0, bin} < (IW + 1)'(N));

endmodule

// File: rtl/rs_slot_alloc.sv
// RS slot allocator: grants the lowest free entry each cycle and decodes issue frees.
module rs_slot_alloc
    import rs_slot_alloc_pkg::*;
#(
    parameter int N = RS_SIZE
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic                   alloc_req,
    input  logic                   free_valid,
    input  logic [$clog2(N)-1:0]   free_idx,
    output logic                   alloc_gnt,
    output logic [N-1:0]           alloc_oh,
    output logic [$clog2(N)-1:0]   alloc_idx,
    output logic [N-1:0]           busy,
    output logic [$clog2(N+1)-1:0] free_count,
    output logic                   full,
    output logic                   empty,
    output logic                   free_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [N-1:0]  alloc_dec;
    logic          alloc_in_range;
    logic [N-1:0]  free_dec;
    logic          free_in_range;
    logic          free_legal;
    logic [N-1:0]  free_oh;
    logic [N-1:0]  busy_nxt;
    logic [CW-1:0] count_nxt;

    // Priority pick: scanning downward leaves the lowest free index last written.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                pick_idx   = IW'(i);
                pick_found = 1'b1;
            end
        end
    end

    assign alloc_gnt = alloc_req & ~full & ~squash & pick_found;
    assign alloc_idx = alloc_gnt ? pick_idx : '0;

    binary_to_onehot_RS #(.N(N)) u_alloc_dec (
        .bin      (alloc_idx),
        .oh       (alloc_dec),
        .in_range (alloc_in_range)
    );

    assign alloc_oh = (alloc_gnt && alloc_in_range) ? alloc_dec : '0;

    binary_to_onehot_RS #(.N(N)) u_free_dec (
        .bin      (free_idx),
        .oh       (free_dec),
        .in_range (free_in_range)
    );

    // A free only counts when it names a real, currently occupied entry.
    assign free_legal = free_valid & free_in_range & (|(free_dec & busy));
    assign free_oh    = free_legal ? free_dec : '0;
    assign free_err   = free_valid & ~squash & ~free_legal;

    // Alloc targets a non-busy entry and a legal free a busy one, so they never collide.
    assign busy_nxt  = (busy & ~free_oh) | alloc_oh;
    assign count_nxt = free_count + CW'(free_legal) - CW'(alloc_gnt);

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            busy       <= '0;
            free_count <= CW'(N);
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            busy       <= busy_nxt;
            free_count <= count_nxt;
            full       <= (count_nxt == '0);
            empty      <= (count_nxt == CW'(N));
        end
    end

    count_matches_busy: assert property (
        @(posedge clock) disable iff (reset)
        free_count == CW'(N - $countones(busy))
    );

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed scoreboard bench for rs_slot_alloc with an N=8 and an N=6 instance.
module tb_rs_slot_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sq = 1'b0, req = 1'b0, fv = 1'b0;
    logic [2:0] fi = '0;
    logic       req6 = 1'b0, fv6 = 1'b0;
    logic [2:0] fi6 = '0;

    logic       gnt, err, full, empty;
    logic [7:0] oh, busy;
    logic [2:0] idx;
    logic [3:0] cnt;

    logic       gnt6, err6, full6, empty6;
    logic [5:0] oh6, busy6;
    logic [2:0] idx6, cnt6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rs_slot_alloc #(.N(8)) u8 (
        .clock(clk), .reset(rst), .squash(sq), .alloc_req(req),
        .free_valid(fv), .free_idx(fi), .alloc_gnt(gnt), .alloc_oh(oh),
        .alloc_idx(idx), .busy(busy), .free_count(cnt), .full(full),
        .empty(empty), .free_err(err)
    );

    rs_slot_alloc #(.N(6)) u6 (
        .clock(clk), .reset(rst), .squash(1'b0), .alloc_req(req6),
        .free_valid(fv6), .free_idx(fi6), .alloc_gnt(gnt6), .alloc_oh(oh6),
        .alloc_idx(idx6), .busy(busy6), .free_count(cnt6), .full(full6),
        .empty(empty6), .free_err(err6)
    );

    typedef struct {
        string      nm;
        logic       chk_g;
        logic       gnt;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       chk_s;
        logic [7:0] busy;
        logic [3:0] cnt;
        logic       chk_e;
        logic       err;
        logic       chk_s6;
        logic [5:0] busy6;
        logic [2:0] cnt6;
        logic       chk_e6;
        logic       err6;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t none();
        exp_t e;
        e.nm = ""; e.chk_g = 0; e.gnt = 0; e.idx = 0; e.oh = 0;
        e.chk_s = 0; e.busy = 0; e.cnt = 0; e.chk_e = 0; e.err = 0;
        e.chk_s6 = 0; e.busy6 = 0; e.cnt6 = 0; e.chk_e6 = 0; e.err6 = 0;
        return e;
    endfunction

    function automatic exp_t g(exp_t e, logic gn, logic [2:0] ix, logic [7:0] o);
        e.chk_g = 1; e.gnt = gn; e.idx = ix; e.oh = o;
        return e;
    endfunction

    function automatic exp_t s(exp_t e, logic [7:0] b, logic [3:0] c);
        e.chk_s = 1; e.busy = b; e.cnt = c;
        return e;
    endfunction

    function automatic exp_t er(exp_t e, logic v);
        e.chk_e = 1; e.err = v;
        return e;
    endfunction

    function automatic exp_t s6(exp_t e, logic [5:0] b, logic [2:0] c);
        e.chk_s6 = 1; e.busy6 = b; e.cnt6 = c;
        return e;
    endfunction

    function automatic exp_t er6(exp_t e, logic v);
        e.chk_e6 = 1; e.err6 = v;
        return e;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h at %0t", nm, fld, act, want, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and checks it mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk_g) begin
                chk(e.nm, "gnt", 32'(gnt), 32'(e.gnt));
                chk(e.nm, "idx", 32'(idx), 32'(e.idx));
                chk(e.nm, "oh",  32'(oh),  32'(e.oh));
            end
            if (e.chk_s) begin
                chk(e.nm, "busy",  32'(busy),  32'(e.busy));
                chk(e.nm, "count", 32'(cnt),   32'(e.cnt));
                chk(e.nm, "full",  32'(full),  32'(e.cnt == 4'd0));
                chk(e.nm, "empty", 32'(empty), 32'(e.cnt == 4'd8));
            end
            if (e.chk_e) chk(e.nm, "free_err", 32'(err), 32'(e.err));
            if (e.chk_s6) begin
                chk(e.nm, "busy6",  32'(busy6), 32'(e.busy6));
                chk(e.nm, "count6", 32'(cnt6),  32'(e.cnt6));
            end
            if (e.chk_e6) chk(e.nm, "free_err6", 32'(err6), 32'(e.err6));
        end
    end

    task automatic cyc(input string nm, input logic r, input logic q, input logic rq,
                       input logic f, input logic [2:0] i, input exp_t e);
        rst = r; sq = q; req = rq; fv = f; fi = i;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc("reset_cyc", 1, 0, 0, 0, 0, none());
        cyc("reset_state", 0, 0, 0, 0, 0, s6(er(g(s(none(), 8'h00, 4'd8), 0, 0, 8'h00), 0), 6'h00, 3'd6));

        for (int k = 0; k < 8; k++) begin
            cyc("fill", 0, 0, 1, 0, 0,
                g(s(none(), 8'((1 << k) - 1), 4'(8 - k)), 1, 3'(k), 8'(1 << k)));
        end
        cyc("req_when_full", 0, 0, 1, 0, 0, g(s(none(), 8'hFF, 4'd0), 0, 0, 8'h00));
        cyc("full_free_no_bypass", 0, 0, 1, 1, 3'd5, er(g(s(none(), 8'hFF, 4'd0), 0, 0, 8'h00), 0));
        cyc("regrant_5", 0, 0, 1, 0, 0, g(s(none(), 8'hDF, 4'd1), 1, 3'd5, 8'h20));
        cyc("squash", 0, 1, 1, 1, 3'd3, er(g(s(none(), 8'hFF, 4'd0), 0, 0, 8'h00), 0));
        cyc("after_squash", 0, 0, 0, 0, 0, s(none(), 8'h00, 4'd8));

        for (int k = 0; k < 4; k++) begin
            cyc("refill", 0, 0, 1, 0, 0,
                g(s(none(), 8'((1 << k) - 1), 4'(8 - k)), 1, 3'(k), 8'(1 << k)));
        end
        cyc("alloc_and_free", 0, 0, 1, 1, 3'd2, er(g(s(none(), 8'h0F, 4'd4), 1, 3'd4, 8'h10), 0));
        cyc("hole_at_2", 0, 0, 1, 0, 0, g(s(none(), 8'h1B, 4'd4), 1, 3'd2, 8'h04));
        cyc("grant_5", 0, 0, 1, 0, 0, g(s(none(), 8'h1F, 4'd3), 1, 3'd5, 8'h20));
        cyc("free_0", 0, 0, 0, 1, 3'd0, er(s(none(), 8'h3F, 4'd2), 0));
        cyc("free_1", 0, 0, 0, 1, 3'd1, er(s(none(), 8'h3E, 4'd3), 0));
        cyc("mid_reset", 1, 0, 1, 0, 0, s(none(), 8'h3C, 4'd4));
        cyc("post_reset", 0, 0, 0, 0, 0, s(none(), 8'h00, 4'd8));

        req6 = 1;
        cyc("first_grant", 0, 0, 1, 0, 0, s6(g(s(none(), 8'h00, 4'd8), 1, 3'd0, 8'h01), 6'h00, 3'd6));
        req6 = 0; fv6 = 1; fi6 = 3'd7;
        cyc("illegal_free", 0, 0, 0, 1, 3'd6, er6(s6(er(s(none(), 8'h01, 4'd7), 1), 6'h01, 3'd5), 1));
        fi6 = 3'd0;
        cyc("after_illegal", 0, 0, 0, 0, 0, er6(s6(er(s(none(), 8'h01, 4'd7), 0), 6'h01, 3'd5), 0));
        fv6 = 0;
        cyc("n6_freed", 0, 0, 0, 0, 0, s6(none(), 6'h00, 3'd6));

        repeat (2) @(posedge clk);
        chk("scoreboard", "leftover", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
